// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared types and constants for the interval timer.
//   state_e       - controller state encoding (IDLE/RUN/PAUSED/DONE)
//   MODE_*        - values of the latched mode bit
//   *_DEF         - default datapath widths
package timer_ctrl_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int PRESCALE_W_DEF = 8;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock into count steps of (prescale_i+1) clocks.
//   clk_i      - clock
//   rst_i      - synchronous active-high reset
//   clr_i      - return the divider to phase 0 (wins over en_i)
//   en_i       - advance the divider this cycle
//   prescale_i - terminal value; a step is every prescale_i+1 enabled clocks
//   step_o     - high on the enabled cycle that completes a division
module tick_prescaler
  import timer_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  step_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A step completes on the edge where the divider sits at its terminal value.
  assign step_o = en_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = step_o ? '0 : cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable one-shot / periodic interval timer.
//   clk_i      - clock (rising edge)
//   rst_i      - synchronous active-high reset
//   start_i    - strobe: latch period/prescale/mode and restart (ignored if period_i==0)
//   stop_i     - strobe: abort to IDLE (highest priority)
//   mode_i     - 0 one-shot, 1 periodic (sampled with start_i)
//   period_i   - count steps per expiry (sampled with start_i)
//   prescale_i - clocks per step minus one (sampled with start_i)
//   pause_i    - level freeze; exists only when TIMER_CTRL_PAUSE_EN is defined
//   count_o    - current step count, 0..period-1
//   busy_o     - RUN or PAUSED
//   done_o     - one-shot finished
//   tick_o     - registered one-cycle pulse per expiry
// Build option: define TIMER_CTRL_PAUSE_EN to add pause_i and the PAUSED state.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  mode_i,
  input  logic [WIDTH-1:0]      period_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
`ifdef TIMER_CTRL_PAUSE_EN
  input  logic                  pause_i,
`endif
  output logic [WIDTH-1:0]      count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tick_o
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  mode_q, mode_d;
  logic                  tick_q, tick_d;

  logic start_ok, active, pause_w, pre_en, pre_clr, step, last_step;

`ifdef TIMER_CTRL_PAUSE_EN
  assign pause_w = pause_i;
`else
  assign pause_w = 1'b0;
`endif

  assign start_ok  = start_i && (period_i != '0);
  assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  // Divider runs on the resume edge too, so a pause of N cycles costs exactly N.
  assign pre_en    = active && !pause_w;
  assign pre_clr   = stop_i || start_ok;
  assign last_step = (count_q == period_q - WIDTH'(1));

  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (pre_clr),
    .en_i       (pre_en),
    .prescale_i (prescale_q),
    .step_o     (step)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start_ok) begin
      state_d    = ST_RUN;
      count_d    = '0;
      period_d   = period_i;
      prescale_d = prescale_i;
      mode_d     = mode_i;
    end else begin
      case (state_q)
        ST_RUN, ST_PAUSED: begin
          state_d = ST_RUN;
          if (pause_w) state_d = ST_PAUSED;
          // step is already gated off while pausing
          if (step) begin
            if (last_step) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      tick_q     <= tick_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = active;
  assign done_o  = (state_q == ST_DONE);
  assign tick_o  = tick_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl with an elapsed-time reference model.
// The model tracks clocks elapsed inside the current period; count is that divided
// by the step length, and expiry is reaching period*(prescale+1).
module tb_timer_ctrl;
  localparam int W  = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, mode = 1'b0, pause = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic          busy, done, tick;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  timer_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .stop_i     (stop),
    .mode_i     (mode),
    .period_i   (period),
    .prescale_i (prescale),
`ifdef TIMER_CTRL_PAUSE_EN
    .pause_i    (pause),
`endif
    .count_o    (count),
    .busy_o     (busy),
    .done_o     (done),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model: 0 idle, 1 running/paused, 2 done
  int              m_st = 0;
  longint unsigned m_e = 0, m_per = 0, m_ps = 0;
  logic            m_mode = 1'b0, m_tick = 1'b0;

  always @(posedge clk) begin
    m_tick = 1'b0;
    if (rst) begin
      m_st = 0; m_e = 0; m_per = 0; m_ps = 0; m_mode = 1'b0;
    end else if (stop) begin
      m_st = 0; m_e = 0;
    end else if (start && period != '0) begin
      m_st = 1; m_e = 0; m_per = period; m_ps = prescale; m_mode = mode;
    end else if (m_st == 1 && !pause) begin
      m_e++;
      if (m_e == m_per * (m_ps + 1)) begin
        m_tick = 1'b1;
        m_e = 0;
        if (!m_mode) m_st = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", count, (m_st == 1) ? m_e / (m_ps + 1) : 0);
      chk("model_busy",  busy,  m_st == 1);
      chk("model_done",  done,  m_st == 2);
      chk("model_tick",  tick,  m_tick);
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [W-1:0] p, logic [PW-1:0] ps, logic md);
    period = p; prescale = ps; mode = md; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int nt, last, lat, seen;
    // reset held two cycles
    rst = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_tick",  tick,  0);
    rst = 1'b0;

    // one-shot period 4, prescale 0
    do_start(4, 0, 1'b0);
    chk("os_busy_e0",  busy,  1);
    chk("os_count_e0", count, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("os_count", count, i);
      chk("os_tick_low", tick, 0);
    end
    cyc();
    chk("os_tick_e4",  tick,  1);
    chk("os_done_e4",  done,  1);
    chk("os_busy_e4",  busy,  0);
    chk("os_count_e4", count, 0);
    cyc();
    chk("os_tick_e5", tick, 0);
    chk("os_done_e5", done, 1);

    // period 0 start in DONE is ignored
    do_start(0, 3, 1'b1);
    chk("illegal_done", done, 1);
    chk("illegal_busy", busy, 0);

    // periodic period 3, prescale 2: tick every 9 clocks
    do_start(3, 2, 1'b1);
    cyc(3);
    chk("per_count_e3", count, 1);
    nt = 0; last = 0;
    for (int c = 4; c <= 50 && nt < 5; c++) begin
      cyc();
      if (tick) begin
        nt++;
        chk("per_tick_interval", c - last, 9);
        last = c;
      end
    end
    chk("per_tick_count", nt, 5);

    // period 0 start while running is ignored; model keeps checking phase
    do_start(0, 0, 1'b0);
    chk("illegal_run_busy", busy, 1);
    cyc(4);

    // stop and start together: stop wins
    period = 7; prescale = 0; mode = 1'b1; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("stopstart_busy",  busy,  0);
    chk("stopstart_done",  done,  0);
    chk("stopstart_count", count, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (tick) seen++;
      cyc();
    end
    chk("stopstart_no_tick", seen, 0);

    // restart mid-period: old tick (edge 6) must not appear, new one at +4
    do_start(3, 1, 1'b1);
    cyc(3);
    do_start(2, 1, 1'b0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (tick) begin lat = c; break; end
    end
    chk("restart_latency", lat, 4);
    chk("restart_done", done, 1);

    // reset in the middle of a run
    do_start(100, 0, 1'b1);
    cyc(5);
    rst = 1'b1;
    cyc();
    chk("midrst_count", count, 0);
    chk("midrst_busy",  busy,  0);
    chk("midrst_done",  done,  0);
    chk("midrst_tick",  tick,  0);
    rst = 1'b0;

    // largest legal period
    do_start('1, 0, 1'b0);
    cyc(10);
    chk("maxper_count", count, 10);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("maxper_stop_busy", busy, 0);

`ifdef TIMER_CTRL_PAUSE_EN
    // one-shot 8 clocks, 5 paused clocks: expiry moves from edge 8 to 13
    do_start(4, 1, 1'b0);
    cyc(2);
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    chk("pause_count_frozen", count, 1);
    chk("pause_busy", busy, 1);
    lat = -1;
    for (int c = 8; c <= 30; c++) begin
      cyc();
      if (tick) begin lat = c; break; end
    end
    chk("pause_expiry_edge", lat, 13);
`endif

    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
